// File: rtl/dmem_avalon_slave.sv
// dmem_avalon_slave: Avalon-MM data memory for the core's load/store unit.
// Writes complete in one cycle with per-lane byteenables; reads take three
// cycles (accept, RAM access, response) and return the full 32-bit word.
module dmem_avalon_slave #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 10
) (
    input  logic                 DMEM_CLOCK_50,
    input  logic                 DMEM_RESET_InHigh,
    input  logic [ADDRWIDTH-1:0] DMEM_Address_InBUS,
    input  logic                 DMEM_Read_In,
    input  logic                 DMEM_Write_In,
    input  logic [3:0]           DMEM_Byteenable_InBUS,
    input  logic [DATAWIDTH-1:0] DMEM_WriteData_InBUS,
    output logic [DATAWIDTH-1:0] DMEM_ReadData_OutBUS,
    output logic                 DMEM_WaitRequest_Out,
    output logic                 DMEM_ReadDataValid_Out,
    output logic                 DMEM_Error_Out
);

    localparam int unsigned LANES = DATAWIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDRWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_ACCESS = 2'd1,
        ST_RD_RESP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
    logic                   wait_q, wait_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;
    logic                   mem_we_c;

    logic [DATAWIDTH-1:0]   mem_q [DEPTH];

    // Next-state, request decode and registered-output values
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        mem_we_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DMEM_Read_In && DMEM_Write_In) begin
                    // Conflicting request: flag it, touch nothing
                    error_d = 1'b1;
                end else if (DMEM_Write_In) begin
                    mem_we_c = 1'b1;
                end else if (DMEM_Read_In) begin
                    addr_d  = DMEM_Address_InBUS;
                    state_d = ST_RD_ACCESS;
                end
            end
            ST_RD_ACCESS: begin
                // Synchronous RAM read lands in the output register
                rdata_d = mem_q[addr_q];
                valid_d = 1'b1;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Busy whenever the next cycle is not an accepting IDLE cycle
        wait_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge DMEM_CLOCK_50) begin
        if (DMEM_RESET_InHigh) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            wait_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Memory array: byte-lane writes, no reset of contents
    always_ff @(posedge DMEM_CLOCK_50) begin
        if (mem_we_c && !DMEM_RESET_InHigh) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (DMEM_Byteenable_InBUS[i]) begin
                    mem_q[DMEM_Address_InBUS][8*i +: 8] <= DMEM_WriteData_InBUS[8*i +: 8];
                end
            end
        end
    end

    assign DMEM_ReadData_OutBUS   = rdata_q;
    assign DMEM_WaitRequest_Out   = wait_q;
    assign DMEM_ReadDataValid_Out = valid_q;
    assign DMEM_Error_Out         = error_q;

endmodule

// File: tb/tb_dmem_avalon_slave.sv
// Bench for dmem_avalon_slave: directed vector table, hand-written corner
// sequences and random traffic, all checked against a transaction-timing model.
module tb_dmem_avalon_slave;

    logic        clk;
    logic        rst;
    logic [9:0]  addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        waitreq;
    logic        rvalid;
    logic        err;

    dmem_avalon_slave dut (
        .DMEM_CLOCK_50          (clk),
        .DMEM_RESET_InHigh      (rst),
        .DMEM_Address_InBUS     (addr),
        .DMEM_Read_In           (rd),
        .DMEM_Write_In          (wr),
        .DMEM_Byteenable_InBUS  (be),
        .DMEM_WriteData_InBUS   (wdata),
        .DMEM_ReadData_OutBUS   (rdata),
        .DMEM_WaitRequest_Out   (waitreq),
        .DMEM_ReadDataValid_Out (rvalid),
        .DMEM_Error_Out         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: memory image plus timing rules of the bus protocol
    logic [31:0] mem_m [1024];
    int          k;            // current cycle index
    int          next_accept;  // first cycle the slave can accept again
    int          valid_at;     // cycle in which a response is due
    int          err_at;       // cycle in which an error pulse is due
    logic [31:0] pend_data;
    logic [31:0] last_data;

    // Observations from the most recent cycle
    bit          seen_v;
    bit          seen_e;
    logic [31:0] seen_d;
    bit          accepted;
    logic [31:0] seen_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, act, exp);
        end
    endtask

    // Drive one cycle of bus inputs, check this cycle's outputs, advance the model
    task automatic cycle(input logic r, input logic i_rd, input logic i_wr,
                         input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] mask;
        rst = r; rd = i_rd; wr = i_wr; addr = a; be = b; wdata = d;
        if (k == valid_at) last_data = pend_data;
        chk("waitrequest", 32'(waitreq), 32'(k < next_accept));
        chk("readdatavalid", 32'(rvalid), 32'(k == valid_at));
        chk("readdata", rdata, last_data);
        chk("error", 32'(err), 32'(k == err_at));
        seen_v = rvalid;
        seen_e = err;
        seen_d = rdata;
        if (rvalid) seen_q.push_back(rdata);
        accepted = 1'b0;
        if (r) begin
            next_accept = k + 1;
            valid_at    = -1;
            err_at      = -1;
            last_data   = 32'h0;
        end else if (k >= next_accept) begin
            if (i_rd && i_wr) begin
                err_at = k + 1;
            end else if (i_wr) begin
                mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                mem_m[a] = (mem_m[a] & ~mask) | (d & mask);
                accepted = 1'b1;
            end else if (i_rd) begin
                pend_data   = mem_m[a];
                valid_at    = k + 2;
                next_accept = k + 3;
                accepted    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    endtask

    // Directed vectors: op 0=write, 1=read, 2=read+write together
    typedef struct {
        int          op;
        logic [9:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic do_vec(input vec_t v);
        bit got;
        if (v.op == 0) begin
            cycle(1'b0, 1'b0, 1'b1, v.a, v.b, v.d);
        end else if (v.op == 2) begin
            cycle(1'b0, 1'b1, 1'b1, v.a, v.b, v.d);
            idle(1);
            chk("illegal_err_pulse", 32'(seen_e), 32'd1);
            idle(1);
            chk("illegal_err_once", 32'(seen_e), 32'd0);
        end else begin
            cycle(1'b0, 1'b1, 1'b0, v.a, v.b, v.d);
            got = 1'b0;
            for (int i = 0; i < 6 && !got; i++) begin
                idle(1);
                if (seen_v) begin
                    got = 1'b1;
                    chk("vec_rdata", seen_d, v.exp);
                    chk("vec_latency", 32'(i), 32'd1);
                end
            end
            if (!got) chk("vec_rd_timeout", 32'd0, 32'd1);
            idle(1);
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   nv;
        int   op;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        k = 0; next_accept = 0; valid_at = -1; err_at = -1;
        pend_data = 32'h0; last_data = 32'h0;

        // Reset values over idle cycles
        idle(3);

        vecs.push_back('{0, 10'd5,  4'b1111, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{0, 10'd5,  4'b0001, 32'h000000AA, 32'h0});
        vecs.push_back('{1, 10'd5,  4'b0000, 32'h0,        32'hDEADBEAA});
        vecs.push_back('{0, 10'd7,  4'b1111, 32'h12345678, 32'h0});
        vecs.push_back('{0, 10'd7,  4'b0011, 32'h0000CAFE, 32'h0});
        vecs.push_back('{0, 10'd7,  4'b0000, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{1, 10'd7,  4'b1111, 32'h0,        32'h1234CAFE});
        vecs.push_back('{0, 10'd9,  4'b1111, 32'h99999999, 32'h0});
        vecs.push_back('{2, 10'd9,  4'b1111, 32'h01234567, 32'h0});
        vecs.push_back('{1, 10'd9,  4'b0000, 32'h0,        32'h99999999});
        vecs.push_back('{0, 10'd10, 4'b1111, 32'h00000000, 32'h0});
        vecs.push_back('{0, 10'd10, 4'b0101, 32'hAABBCCDD, 32'h0});
        vecs.push_back('{1, 10'd10, 4'b0110, 32'h0,        32'h00BB00DD});
        vecs.push_back('{0, 10'd11, 4'b1100, 32'h5A5A0000, 32'h0});
        vecs.push_back('{1, 10'd11, 4'b0000, 32'h0,        32'h5A5A0000});
        for (int i = 0; i < vecs.size(); i++) do_vec(vecs[i]);

        // Back-to-back writes, then three reads held through WaitRequest
        cycle(1'b0, 1'b0, 1'b1, 10'd1, 4'hF, 32'h11);
        cycle(1'b0, 1'b0, 1'b1, 10'd2, 4'hF, 32'h22);
        cycle(1'b0, 1'b0, 1'b1, 10'd3, 4'hF, 32'h33);
        seen_q.delete();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                cycle(1'b0, 1'b1, 1'b0, 10'(i + 1), 4'hF, 32'h0);
        idle(3);
        chk("held_read_count", 32'(seen_q.size()), 32'd3);
        if (seen_q.size() == 3) begin
            chk("held_read_0", seen_q[0], 32'h11);
            chk("held_read_1", seen_q[1], 32'h22);
            chk("held_read_2", seen_q[2], 32'h33);
        end

        // Reset in the RD_ACCESS cycle aborts the read
        cycle(1'b0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        seen_q.delete();
        cycle(1'b1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        chk("rst_wait_low", 32'(waitreq), 32'd0);
        chk("rst_rdata_zero", rdata, 32'h0);
        idle(5);
        chk("rst_abort_no_valid", 32'(seen_q.size()), 32'd0);
        do_vec('{1, 10'd5, 4'h0, 32'h0, 32'hDEADBEAA});

        // Reset coincident with a write drops the write
        cycle(1'b1, 1'b0, 1'b1, 10'd5, 4'hF, 32'h0BADF00D);
        idle(1);
        do_vec('{1, 10'd5, 4'h0, 32'h0, 32'hDEADBEAA});

        // Random traffic over a small initialised window
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, 10'(i), 4'hF, $urandom);
        nv = 0;
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 19));
            cycle(($urandom_range(0, 59) == 0),
                  (op >= 8 && op < 14) || op == 19,
                  (op >= 2 && op < 8)  || op == 19,
                  10'($urandom_range(0, 15)), 4'($urandom), $urandom);
            if (seen_v) nv++;
        end
        idle(4);
        chk("random_saw_responses", 32'(nv > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_avalon_slave.md
# dmem_avalon_slave

Avalon-MM slave data memory that answers the core's load/store unit on the data bus. It accepts word-addressed read and write transfers and applies per-lane byteenables on writes. It returns full 32-bit words on reads, leaving sign/zero extension to the load path. It sits between the core's data-bus master port and the on-chip RAM, serialising transfers through a small request/response state machine.

## Interface
Parameters:
- DATAWIDTH, 32, data word width; fixed at 32 (4 byte lanes).
- ADDRWIDTH, 10, word-address width; depth = 2^ADDRWIDTH words.

Ports:
- DMEM_CLOCK_50  in  1  system clock; all state updates on rising edge.
- DMEM_RESET_InHigh  in  1  reset; synchronous, active-high.
- DMEM_Address_InBUS  in  ADDRWIDTH  word address.
- DMEM_Read_In  in  1  read request.
- DMEM_Write_In  in  1  write request.
- DMEM_Byteenable_InBUS  in  4  lane enables; bit i qualifies bits [8i+7:8i].
- DMEM_WriteData_InBUS  in  DATAWIDTH  write data, lane-aligned (byte/half in low lanes).
- DMEM_ReadData_OutBUS  out  DATAWIDTH  read data, registered.
- DMEM_WaitRequest_Out  out  1  slave busy; master must hold request while high.
- DMEM_ReadDataValid_Out  out  1  one-cycle pulse qualifying ReadData.
- DMEM_Error_Out  out  1  one-cycle pulse on illegal request (read and write together).

## Operation
- FSM states: IDLE, RD_ACCESS, RD_RESP. All outputs driven from registers.
- IDLE: WaitRequest=0.
  - Write=1, Read=0: transfer accepted.
  - At the edge, each lane i with Byteenable[i]=1 writes WriteData[8i+7:8i] to mem[Address].
  - Lanes with 0 keep their old value.
  - State stays IDLE, so back-to-back writes run one per cycle.
  - Byteenable=4'b0000: accepted; memory unchanged.
  - Non-contiguous enables (e.g. 4'b0101) are honoured per lane.
  - Read=1, Write=0: accepted. Address is latched, WaitRequest goes to 1, next state is RD_ACCESS. Byteenable is ignored on reads; the full word is returned.
  - Read=1, Write=1: no access. Error_Out=1 for the next cycle. Stay IDLE.
  - Neither asserted: stay IDLE.
- RD_ACCESS: WaitRequest=1.
  - Synchronous RAM read of the latched address.
  - Requests on the bus are ignored.
  - Next state is RD_RESP.
- RD_RESP: WaitRequest=1.
  - ReadData is loaded with the RAM output and ReadDataValid=1 for this single cycle.
  - Next state is IDLE, where WaitRequest returns to 0.
- ReadData holds its last value until the next read response.
- ReadDataValid is 0 in every cycle other than RD_RESP.
- Memory contents are not initialised by reset; preload comes only from a simulation init file.

## Timing
- Reset values: state=IDLE, ReadData=0, ReadDataValid=0, WaitRequest=0, Error=0.
- Write latency: data is in the array at the accepting edge. A read issued the following cycle returns the new value.
- Read issued in IDLE at cycle N:
  - WaitRequest=1 in N+1 and N+2.
  - ReadDataValid=1 with data in N+2.
  - WaitRequest=0 in N+3, the earliest next accept.
- Read throughput: one read per 3 cycles.
- A master holding Read high during WaitRequest sees the request accepted once. If Read is still high in N+3, it is a new read.
- Reset asserted during RD_ACCESS or RD_RESP: read aborted. No ReadDataValid pulse is produced after the reset edge, and all outputs take reset values at that edge.
- Reset coincident with a write in IDLE: the write is dropped.
- Error_Out is registered: it appears one cycle after the illegal request and lasts 1 cycle.

## Test plan
- Reset, then idle 3 cycles -> ReadData=0, ReadDataValid=0, WaitRequest=0, Error=0 every cycle.
- Write addr 5, data 0xDEADBEEF, BE 1111; then write addr 5, data 0x000000AA, BE 0001; then read addr 5 -> valid pulse exactly 2 cycles after accept with ReadData=0xDEADBEAA; WaitRequest high for exactly 2 cycles.
- Write addr 7, data 0x12345678, BE 1111; write addr 7, data 0x0000CAFE, BE 0011; write addr 7, data 0xFFFFFFFF, BE 0000; read addr 7 -> 0x1234CAFE.
- Three writes on consecutive cycles to addr 1,2,3 (values 0x11,0x22,0x33), then three reads held high through WaitRequest -> one valid pulse every 3 cycles, data 0x11, 0x22, 0x33 in order; no duplicate responses.
- Read=1 and Write=1 together at addr 9 -> Error_Out high for one cycle; no ReadDataValid; a subsequent read of addr 9 returns its prior contents unchanged.
- Issue read, assert reset in the RD_ACCESS cycle -> no ReadDataValid ever fires for that read; WaitRequest=0 and ReadData=0 after the reset edge; a new read afterwards completes normally.
